// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (port P)
// and a debug/loader port (port D). Every access runs the same three steps:
// grant (IDLE or COMPLETE) -> ACCESS (one memory cycle) -> COMPLETE (done/ack).
// From IDLE the pipeline wins a tie. From COMPLETE the other port goes next
// if it is requesting, so under continuous load the two ports alternate.
//
// Optional build macro: DMEM_ARB_ALIGN_CHK_EN
//   Adds a sticky align_err output. A granted access whose addr[1:0] != 0
//   is not driven to memory, still completes on time, and a read returns 0.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   p_req/p_we/p_addr/p_wdata pipeline request (held until p_done)
//   p_rdata, p_done          pipeline load data, one-cycle completion pulse
//   p_stall                  combinational freeze request to hazard logic
//   d_req/d_we/d_addr/d_wdata debug request (held until d_ack)
//   d_rdata, d_ack           debug read data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (registered)
//   mem_rdata                memory read data, valid the cycle after mem_en
//   align_err                (macro only) sticky misalignment flag
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_done,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_ALIGN_CHK_EN
    ,
    output logic              align_err
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
    typedef enum logic {OWN_P, OWN_D} owner_t;

    state_t state, state_nxt;
    owner_t owner, owner_nxt;

    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_mis;

    logic              we_q;
    logic              mis_q;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              rd_complete;
    logic [DATA_W-1:0] rd_val;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_P;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state / grant decision
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (p_req) begin
                    grant     = 1'b1;
                    owner_nxt = OWN_P;
                end else if (d_req) begin
                    grant     = 1'b1;
                    owner_nxt = OWN_D;
                end
            end
            ACCESS: state_nxt = COMPLETE;
            COMPLETE: begin
                // The finishing owner's request is ignored here, so a waiting
                // port is always served next.
                state_nxt = IDLE;
                if (owner == OWN_P && d_req) begin
                    grant     = 1'b1;
                    owner_nxt = OWN_D;
                end else if (owner == OWN_D && p_req) begin
                    grant     = 1'b1;
                    owner_nxt = OWN_P;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant) state_nxt = ACCESS;
    end

    assign sel_we    = (owner_nxt == OWN_P) ? p_we    : d_we;
    assign sel_addr  = (owner_nxt == OWN_P) ? p_addr  : d_addr;
    assign sel_wdata = (owner_nxt == OWN_P) ? p_wdata : d_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign sel_mis = (sel_addr[1:0] != 2'b00);
`else
    assign sel_mis = 1'b0;
`endif

    assign rd_complete = (state == COMPLETE) && !we_q;
    assign rd_val      = mis_q ? '0 : mem_rdata;

    // mem_rdata only becomes valid during COMPLETE, yet the owner must see it
    // in that same cycle: the output passes it straight through while
    // completing and the register holds it from then on.
    assign p_rdata = (rd_complete && owner == OWN_P) ? rd_val : p_rdata_q;
    assign d_rdata = (rd_complete && owner == OWN_D) ? rd_val : d_rdata_q;

    assign p_stall = p_req & ~(state == COMPLETE && owner == OWN_P);

    // Registered memory command, completion pulses and read-data holding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            p_done    <= 1'b0;
            d_ack     <= 1'b0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
            align_err <= 1'b0;
`endif
        end else begin
            mem_en <= grant & ~sel_mis;
            mem_we <= grant & sel_we & ~sel_mis;
            if (grant) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                we_q      <= sel_we;
                mis_q     <= sel_mis;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                if (sel_mis) align_err <= 1'b1;
`endif
            end
            p_done <= (state == ACCESS) && (owner == OWN_P);
            d_ack  <= (state == ACCESS) && (owner == OWN_D);
            if (rd_complete && owner == OWN_P) p_rdata_q <= rd_val;
            if (rd_complete && owner == OWN_D) d_rdata_q <= rd_val;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic [31:0] p_rdata, d_rdata;
    logic        p_done, p_stall, d_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic        align_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: expected rdata value at each completion, per port
    logic [31:0] pq[$];
    logic [31:0] dq[$];

    // Big-endian byte memory, synchronous read
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_ALIGN_CHK_EN
        , .align_err(align_err)
`endif
    );

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[7:0]]      <= mem_wdata[31:24];
            mem[mem_addr[7:0] + 1]  <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 2]  <= mem_wdata[15:8];
            mem[mem_addr[7:0] + 3]  <= mem_wdata[7:0];
        end
        if (mem_en && !mem_we)
            mem_rdata <= {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 1],
                          mem[mem_addr[7:0] + 2], mem[mem_addr[7:0] + 3]};
    end

    function automatic logic [31:0] word(input int unsigned a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 ns after the edge, retire scoreboard entries
    task automatic tick();
        @(posedge clk);
        #1;
        if (p_done === 1'b1) begin
            if (pq.size() == 0) chk("p_done_spurious", {31'b0, p_done}, 32'd0);
            else chk("p_rdata_sb", p_rdata, pq.pop_front());
        end
        if (d_ack === 1'b1) begin
            if (dq.size() == 0) chk("d_ack_spurious", {31'b0, d_ack}, 32'd0);
            else chk("d_rdata_sb", d_rdata, dq.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = '0;
        rst = 1'b1;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_p_done", {31'b0, p_done}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_p_rdata", p_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        p_req = 1; #1;
        chk("rst_stall_follows_req", {31'b0, p_stall}, 32'd1);
        p_req = 0;
        tick();
        rst = 1'b0;
        tick();

        // P write 0x2A @16
        p_req = 1; p_we = 1; p_addr = 32'd16; p_wdata = 32'h2A;
        pq.push_back(32'h0);
        #1;
        chk("t1_stall_rise", {31'b0, p_stall}, 32'd1);
        tick();
        chk("t1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("t1_mem_we", {31'b0, mem_we}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'd16);
        chk("t1_mem_wdata", mem_wdata, 32'h2A);
        chk("t1_stall_access", {31'b0, p_stall}, 32'd1);
        chk("t1_no_done_yet", {31'b0, p_done}, 32'd0);
        tick();
        chk("t1_p_done", {31'b0, p_done}, 32'd1);
        chk("t1_stall_fall", {31'b0, p_stall}, 32'd0);
        chk("t1_mem_en_off", {31'b0, mem_en}, 32'd0);
        p_req = 0;
        tick();
        chk("t1_done_one_cycle", {31'b0, p_done}, 32'd0);
        chk("t1_word16", word(16), 32'h2A);

        // D read @16
        d_req = 1; d_we = 0; d_addr = 32'd16;
        dq.push_back(32'h2A);
        tick();
        chk("t2_mem_en", {31'b0, mem_en}, 32'd1);
        chk("t2_mem_we", {31'b0, mem_we}, 32'd0);
        chk("t2_no_stall", {31'b0, p_stall}, 32'd0);
        tick();
        chk("t2_d_ack", {31'b0, d_ack}, 32'd1);
        chk("t2_d_rdata", d_rdata, 32'h2A);
        d_req = 0;
        tick();

        // Simultaneous: P write 5@20, D read @20
        p_req = 1; p_we = 1; p_addr = 32'd20; p_wdata = 32'h5;
        d_req = 1; d_we = 0; d_addr = 32'd20;
        pq.push_back(32'h0);
        dq.push_back(32'h5);
        tick();
        chk("t3_p_first_we", {31'b0, mem_we}, 32'd1);
        chk("t3_p_first_addr", mem_addr, 32'd20);
        tick();
        chk("t3_p_done", {31'b0, p_done}, 32'd1);
        chk("t3_d_not_yet", {31'b0, d_ack}, 32'd0);
        p_req = 0;
        tick();
        chk("t3_d_access_no_bubble", {31'b0, mem_en}, 32'd1);
        chk("t3_d_access_read", {31'b0, mem_we}, 32'd0);
        tick();
        chk("t3_d_ack", {31'b0, d_ack}, 32'd1);
        chk("t3_d_rdata", d_rdata, 32'h5);
        d_req = 0;
        tick();

        // Continuous both ports: alternation P,D,P,D,P,D
        p_req = 1; p_we = 0; p_addr = 32'd16;
        d_req = 1; d_we = 0; d_addr = 32'd20;
        for (int i = 0; i < 3; i++) begin
            pq.push_back(32'h2A);
            dq.push_back(32'h5);
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("t4_p_done_c%0d", i), {31'b0, p_done}, (i % 4 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("t4_d_ack_c%0d", i), {31'b0, d_ack}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_mem_en_c%0d", i), {31'b0, mem_en}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        p_req = 0; d_req = 0;
        tick();

        // Reset during D write ACCESS (0xFF@24)
        d_req = 1; d_we = 1; d_addr = 32'd24; d_wdata = 32'hFF;
        tick();
        chk("t5_access", {31'b0, mem_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_mem_en_drop", {31'b0, mem_en}, 32'd0);
        chk("t5_mem_we_drop", {31'b0, mem_we}, 32'd0);
        tick();
        chk("t5_no_ack", {31'b0, d_ack}, 32'd0);
        chk("t5_write_dropped", word(24), 32'h0);
        rst = 1'b0;
        dq.push_back(32'h0);  // rdata cleared by reset, write keeps it
        tick();
        chk("t5_reissue_en", {31'b0, mem_en}, 32'd1);
        chk("t5_reissue_we", {31'b0, mem_we}, 32'd1);
        tick();
        chk("t5_ack", {31'b0, d_ack}, 32'd1);
        d_req = 0;
        tick();
        chk("t5_word24", word(24), 32'hFF);

`ifdef DMEM_ARB_ALIGN_CHK_EN
        // Misaligned P read
        chk("t6_align_clear", {31'b0, align_err}, 32'd0);
        p_req = 1; p_we = 0; p_addr = 32'h11;
        pq.push_back(32'h0);
        tick();
        chk("t6_mem_en_suppressed", {31'b0, mem_en}, 32'd0);
        chk("t6_align_err", {31'b0, align_err}, 32'd1);
        tick();
        chk("t6_p_done", {31'b0, p_done}, 32'd1);
        chk("t6_p_rdata_zero", p_rdata, 32'd0);
        p_req = 0;
        tick(); tick();
        chk("t6_align_sticky", {31'b0, align_err}, 32'd1);
        rst = 1'b1; #1;
        chk("t6_align_rst", {31'b0, align_err}, 32'd0);
        tick();
        rst = 1'b0;
`endif

        chk("pq_drained", pq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
